// File: rtl/bsg_dff_reset_pipe.sv
// bsg_dff_reset_pipe: els_p-stage valid/ready register pipeline with reset value, flush and occupancy count
// Define BSG_DFF_RESET_PIPE_COLLAPSE_EN for a bubble-collapsing ready chain; otherwise the pipe shifts rigidly.
module bsg_dff_reset_pipe #(
  parameter int width_p = -1,
  parameter int els_p = 2,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       ready_i,
  input  logic                       flush_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);
  localparam int cw_lp = $clog2(els_p+1);
  logic [els_p-1:0] v_r, v_in;
  logic [width_p-1:0] data_r [els_p];
  logic [width_p-1:0] data_in [els_p];
  logic [els_p:0] adv;
  assign adv[els_p] = ready_i;
  for (genvar k = 0; k < els_p; k++) begin : g_st
    if (k == 0) begin : g_head
      assign v_in[k] = v_i;
      assign data_in[k] = data_i;
    end else begin : g_body
      assign v_in[k] = v_r[k-1];
      assign data_in[k] = data_r[k-1];
    end
`ifdef BSG_DFF_RESET_PIPE_COLLAPSE_EN
    assign adv[k] = ~v_r[k] | adv[k+1];
`else
    assign adv[k] = ready_i | ~v_r[els_p-1];
`endif
  end
  // data only loads behind a valid so idle stages don't toggle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r <= '0;
      for (int i = 0; i < els_p; i++) data_r[i] <= reset_val_p;
    end else if (flush_i) begin
      v_r <= '0;
    end else begin
      for (int i = 0; i < els_p; i++)
        if (adv[i]) begin
          v_r[i] <= v_in[i];
          if (v_in[i]) data_r[i] <= data_in[i];
        end
    end
  end
  always_comb begin
    count_o = '0;
    for (int i = 0; i < els_p; i++) count_o = count_o + cw_lp'(v_r[i]);
  end
  assign ready_o = adv[0];
  assign v_o = v_r[els_p-1];
  assign data_o = data_r[els_p-1];
endmodule
